// File: rtl/odpc_range_profiler.sv
// Range profiler: learns activation min/max over a window, commits
// guarded bounds, then forwards the live stream through a 1-deep register.
module odpc_range_profiler #(
   parameter int DATA_W  = 8,
   parameter int WIN_LEN = 64,
   parameter int MARGIN  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_x,
   output logic [DATA_W-1:0] data_min,
   output logic [DATA_W-1:0] data_max,
   output logic              bounds_valid,
   output logic              busy,
   output logic              done
);

   localparam int CW = $clog2(WIN_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);
   localparam logic [DATA_W:0] MARG = (DATA_W + 1)'(MARGIN);

   typedef enum logic [1:0] {
      IDLE,
      PROFILE,
      RUN
   } state_t;

   state_t state, state_next;

   logic [CW-1:0]     count;
   logic [DATA_W-1:0] run_min, run_max;
   logic [DATA_W-1:0] nxt_min, nxt_max;
   logic [DATA_W:0]   lo_raw, hi_raw;
   logic [DATA_W-1:0] lo, hi;
   logic              accept, commit;

   assign accept  = in_valid & in_ready;
   assign commit  = (state == PROFILE) & accept & (count == LAST);
   assign nxt_min = (in_data < run_min) ? in_data : run_min;
   assign nxt_max = (in_data > run_max) ? in_data : run_max;

   // Borrow/carry bit of the widened result drives the saturation.
   assign lo_raw = {1'b0, nxt_min} - MARG;
   assign hi_raw = {1'b0, nxt_max} + MARG;
   assign lo     = lo_raw[DATA_W] ? '0 : lo_raw[DATA_W-1:0];
   assign hi     = hi_raw[DATA_W] ? '1 : hi_raw[DATA_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = 1'b0;
      unique case (state)
         IDLE: begin
         end
         PROFILE: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            if (in_valid && count == LAST) begin
               state_next = RUN;
            end
         end
         RUN: begin
            in_ready = !out_valid | out_ready;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      // A sample offered alongside start belongs to no window.
      if (start) begin
         state_next = PROFILE;
         in_ready   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count        <= '0;
         run_min      <= '1;
         run_max      <= '0;
         data_min     <= '0;
         data_max     <= '1;
         bounds_valid <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= commit;
         if (start) begin
            count   <= '0;
            run_min <= '1;
            run_max <= '0;
         end else if (state == PROFILE && accept) begin
            count   <= count + CW'(1);
            run_min <= nxt_min;
            run_max <= nxt_max;
         end
         if (commit) begin
            data_min     <= lo;
            data_max     <= hi;
            bounds_valid <= 1'b1;
         end
      end
   end

   // Loads only happen in RUN; a pending word may drain in any state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         data_x    <= '0;
      end else if (state == RUN && accept) begin
         out_valid <= 1'b1;
         data_x    <= in_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/odpc_range_profiler.md
Name: odpc_range_profiler

Overview:
- Upstream stage of the data processing module. Learns per-channel activation bounds over a profiling window of WIN_LEN samples.
- After the window, commits the bounds to data_min/data_max and holds them stable.
- Then forwards the live activation stream as data_x through a one-deep valid/ready register, so the comparator sees x alongside stable bounds.

Parameters:
- DATA_W, 8, width of activations and bounds (unsigned).
- WIN_LEN, 64, samples per profiling window (>=1).
- MARGIN, 0, guard band: subtracted from min, added to max at commit, saturating.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to (re)start profiling.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input accept; transfer when in_valid & in_ready.
- in_data  in  DATA_W  input activation.
- out_valid  out  1  data_x valid.
- out_ready  in  1  downstream accept.
- data_x  out  DATA_W  forwarded activation (to data processing module).
- data_min  out  DATA_W  committed lower bound.
- data_max  out  DATA_W  committed upper bound.
- bounds_valid  out  1  bounds committed at least once since reset.
- busy  out  1  high in PROFILE.
- done  out  1  one-cycle pulse on commit.

Behaviour:
- Reset values (async, immediate): state IDLE, in_ready 0, out_valid 0, data_x 0, data_min 0x00, data_max 0xFF, bounds_valid 0, busy 0, done 0, count 0, run_min 0xFF, run_max 0x00.
- States:
  - IDLE: in_ready 0, nothing accepted.
  - PROFILE: in_ready 1, busy 1.
  - RUN: forwarding.
- start in any state moves to PROFILE next cycle and clears count=0, run_min=all-ones, run_max=0.
  - A sample offered in the same cycle as start is not accepted: in_ready is forced 0 that cycle.
  - start in PROFILE restarts the window.
- PROFILE, per accepted sample:
  - run_min = min(run_min, in_data); run_max = max(run_max, in_data); count+1.
  - Samples are consumed, not forwarded.
- Commit, on the accept that makes count == WIN_LEN (that sample included):
  - data_min = max(run_min' − MARGIN, 0); data_max = min(run_max' + MARGIN, 2^DATA_W−1).
  - Arithmetic is done at DATA_W+1 bits, then saturated.
  - bounds_valid=1 and done=1 are registered on that edge; done drops the following cycle.
  - State goes to RUN.
- data_min/data_max change only on commit. During re-profiling the old bounds and bounds_valid=1 are held.
- RUN:
  - in_ready = !out_valid | out_ready.
  - On accept: data_x=in_data, out_valid=1 next cycle.
  - On out_valid & out_ready with no new accept: out_valid=0.
  - Simultaneous accept and drain reloads the register with no bubble: throughput 1/cycle, latency 1 cycle.
  - data_x is held stable while out_valid & !out_ready.
- Output register in PROFILE/IDLE: no new loads. A pending data_x still drains via out_ready, then out_valid falls.
- WIN_LEN=1: the first accepted sample commits.
- Reset mid-profile discards partial statistics; the previously committed bounds are lost (back to 0x00/0xFF, bounds_valid 0).

Test Plan:
- Basic window: WIN_LEN=4, MARGIN=2; start; samples 10,200,50,3 (in_valid continuous).
  - Required: done pulses one cycle after the 4th accept.
  - data_min=1, data_max=202, bounds_valid=1, busy 1→0.
- Saturation: MARGIN=2; samples 1,254,100,100.
  - Required: data_min=0, data_max=255.
- RUN backpressure: after commit, stream 5,6,7 with out_ready low for 3 cycles.
  - Required: data_x holds 5, in_ready 0 while stalled.
  - On release: 5,6,7 emerge in order, no loss or duplication, 1/cycle.
- Restart mid-window: start; samples 9,9; start again; samples 20,30,40,50.
  - Required: data_min=20, data_max=50 (MARGIN=0).
  - A sample offered on the start cycle is not accepted.
- Re-profile from RUN: bounds 20/50 committed; start; samples 0,0,0,0.
  - Required: data_min/data_max stay 20/50 until the 4th accept, then 0/0.
  - bounds_valid stays 1 throughout.
- Async reset mid-profile: assert rst between clock edges after 2 samples.
  - Required: all outputs immediately at reset values (data_min 0x00, data_max 0xFF, bounds_valid 0, out_valid 0).
  - The next start begins a fresh window.
